// File: rtl/led_axil_pkg.sv
// Shared constants and FSM state types for the LED controller AXI4-Lite responder.
//   - Register word offsets (awaddr/araddr bits [3:2])
//   - CTRL bit positions
//   - AXI response code
//   - Write and read channel FSM state enums
package led_axil_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_PATTERN = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_STATIC_BIT = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ACK,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ACK,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/led_axil_responder_blink.sv
// led_blink_gen: prescaled LED blink engine.
//   clk, rst     : clock, synchronous active-high reset
//   enable       : 0 holds counter, phase and led at 0
//   static_mode  : 1 drives the pattern constantly (counter keeps running)
//   period       : blink half-period in clocks, minus 1
//   pattern      : LED pattern shown during the "on" phase
//   led          : registered LED drive
module led_blink_gen #(
  parameter int unsigned LED_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 static_mode,
  input  logic [31:0]          period,
  input  logic [LED_WIDTH-1:0] pattern,
  output logic [LED_WIDTH-1:0] led
);

  logic [31:0] counter;
  logic        phase;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      counter <= '0;
      phase   <= 1'b0;
      led     <= '0;
    end else begin
      // >= rather than == so a PERIOD lowered below the running count
      // wraps immediately; counter never exceeds period, so no overflow.
      if (counter >= period) begin
        counter <= '0;
        phase   <= ~phase;
      end else begin
        counter <= counter + 32'd1;
      end
      if (static_mode) begin
        led <= pattern;
      end else begin
        led <= phase ? pattern : '0;
      end
    end
  end

endmodule

// File: rtl/led_axil_responder.sv
// led_axil_responder: AXI4-Lite slave with four 32-bit registers
// (CTRL, PERIOD, PATTERN, SCRATCH) and an LED blink engine.
//   s00_axi_aclk / s00_axi_areset : clock, synchronous active-high reset
//   s00_axi_aw* / w* / b*         : write address, data, response channels
//   s00_axi_ar* / r*              : read address, data channels
//   led                           : registered LED drive
module led_axil_responder
  import led_axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned LED_WIDTH          = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [LED_WIDTH-1:0]            led
);

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_bresp = RESP_OKAY;
  assign s00_axi_rresp = RESP_OKAY;

  // Write channel: AW and W are only accepted together.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) wr_state <= W_IDLE;
    else                wr_state <= wr_next;
  end

  always_comb begin
    wr_next         = wr_state;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    case (wr_state)
      W_IDLE: if (s00_axi_awvalid && s00_axi_wvalid) wr_next = W_ACK;
      W_ACK: begin
        s00_axi_awready = 1'b1;
        s00_axi_wready  = 1'b1;
        wr_next         = W_RESP;
      end
      W_RESP: begin
        s00_axi_bvalid = 1'b1;
        if (s00_axi_bready) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (wr_state == W_ACK) begin
      for (int unsigned b = 0; b < C_S_AXI_DATA_WIDTH/8; b++) begin
        if (s00_axi_wstrb[b])
          regs[s00_axi_awaddr[3:2]][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
      end
    end
  end

  // Read channel
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) rd_state <= R_IDLE;
    else                rd_state <= rd_next;
  end

  always_comb begin
    rd_next         = rd_state;
    s00_axi_arready = 1'b0;
    s00_axi_rvalid  = 1'b0;
    case (rd_state)
      R_IDLE: if (s00_axi_arvalid) rd_next = R_ACK;
      R_ACK: begin
        s00_axi_arready = 1'b1;
        rd_next         = R_DATA;
      end
      R_DATA: begin
        s00_axi_rvalid = 1'b1;
        if (s00_axi_rready) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Latched on the same edge as a coincident write commit, so a
  // same-address read returns the pre-write contents.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset)          s00_axi_rdata <= '0;
    else if (rd_state == R_ACK)  s00_axi_rdata <= regs[s00_axi_araddr[3:2]];
  end

  led_blink_gen #(.LED_WIDTH(LED_WIDTH)) u_blink (
    .clk         (s00_axi_aclk),
    .rst         (s00_axi_areset),
    .enable      (regs[REG_CTRL][CTRL_ENABLE_BIT]),
    .static_mode (regs[REG_CTRL][CTRL_STATIC_BIT]),
    .period      (regs[REG_PERIOD]),
    .pattern     (regs[REG_PATTERN][LED_WIDTH-1:0]),
    .led         (led)
  );

endmodule

// File: tb/tb_led_axil_responder.sv
// Self-checking bench for led_axil_responder: directed and randomized AXI4-Lite
// traffic against a register-array reference model, plus blink run-length checks.
module tb_led_axil_responder;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  led;

  logic [31:0] mdl [4];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_axil_responder #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .LED_WIDTH(4)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(areset),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .led(led)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead,
                           input int bp, input bit abandon);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b0;
    for (int i = 0; i < w_lead; i++) begin
      @(negedge clk);
      check_eq("w_alone_awready", awready, 0);
      check_eq("w_alone_wready", wready, 0);
    end
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 16) begin @(negedge clk); n++; end
    check_eq("awready", awready, 1);
    check_eq("wready_with_aw", wready, 1);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int b = 0; b < 4; b++)
      if (strb[b]) mdl[addr[3:2]][8*b +: 8] = data[8*b +: 8];
    @(negedge clk);
    check_eq("ack_one_cycle", awready, 0);
    n = 0;
    while (!bvalid && n < 16) begin @(negedge clk); n++; end
    check_eq("bvalid", bvalid, 1);
    check_eq("bresp", bresp, 0);
    for (int i = 0; i < bp; i++) begin
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      check_eq("bp_bvalid", bvalid, 1);
      check_eq("bp_bresp", bresp, 0);
      check_eq("bp_no_aw_accept", awready, 0);
    end
    if (abandon) begin
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    check_eq("bvalid_drop", bvalid, 0);
    check_eq("no_early_aw", awready, 0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp,
                          input int bp, input bit abandon);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 16) begin @(negedge clk); n++; end
    check_eq("arready", arready, 1);
    arvalid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!rvalid && n < 16) begin @(negedge clk); n++; end
    check_eq("rvalid", rvalid, 1);
    check_eq("rresp", rresp, 0);
    check_eq("rdata", rdata, exp);
    for (int i = 0; i < bp; i++) begin
      arvalid = 1'b1;
      @(negedge clk);
      check_eq("bp_rvalid", rvalid, 1);
      check_eq("bp_rdata", rdata, exp);
      check_eq("bp_no_ar_accept", arready, 0);
    end
    if (abandon) begin
      arvalid = 1'b0;
      return;
    end
    rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b0;
    check_eq("rvalid_drop", rvalid, 0);
    check_eq("no_early_ar", arready, 0);
  endtask

  task automatic read_all();
    for (int r = 0; r < 4; r++) begin
      logic [3:0] a;
      a = 4'(r * 4);
      axi_read(a, mdl[r], 0, 1'b0);
    end
  endtask

  // Blink just enabled from the disabled state: runs of led alternate
  // pattern / 0, each exactly period+1 clocks long.
  task automatic check_blink(input logic [31:0] period, input logic [3:0] pat);
    int n;
    int len;
    logic [3:0] cur;
    n = 0;
    while (led != 4'h0 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (led == 4'h0 && n < 200) begin @(negedge clk); n++; end
    check_eq("blink_start", led, pat);
    for (int r = 0; r < 4; r++) begin
      cur = led; len = 0;
      while (led == cur && len < 200) begin @(negedge clk); len++; end
      check_eq("blink_len", len, period + 1);
      check_eq("blink_val", cur, (r % 2 == 0) ? pat : 4'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  a, s, pat;
    logic [31:0] d, per;
    for (int r = 0; r < 4; r++) mdl[r] = '0;
    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (20) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    check_eq("rst_awready", awready, 0);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_arready", arready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_led", led, 0);
    read_all();

    // Sequential write / read-back
    for (int r = 0; r < 4; r++) axi_write(4'(r * 4), 32'(r + 1), 4'hF, 0, 0, 1'b0);
    for (int r = 0; r < 4; r++) axi_read(4'(r * 4), 32'(r + 1), 0, 1'b0);

    // Byte strobes
    axi_write(4'hC, 32'hAABBCCDD, 4'hF, 0, 0, 1'b0);
    axi_write(4'hC, 32'h11223344, 4'h5, 0, 0, 1'b0);
    axi_read(4'hC, 32'hAA22CC44, 0, 1'b0);
    axi_read(4'hC, mdl[3], 0, 1'b0);

    // W presented 5 clocks ahead of AW
    axi_write(4'h8, 32'h0000_0005, 4'hF, 5, 0, 1'b0);
    axi_read(4'h8, mdl[2], 0, 1'b0);

    // Randomized traffic, low address bits included
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 2), 0, 1'b0);
      end else begin
        axi_read(a, mdl[a[3:2]], 0, 1'b0);
      end
    end

    // Blink mode
    axi_write(4'h0, 32'h0, 4'hF, 0, 0, 1'b0);
    @(negedge clk);
    check_eq("disabled_led", led, 0);
    axi_write(4'h8, 32'h0000_000A, 4'hF, 0, 0, 1'b0);
    axi_write(4'h4, 32'd3, 4'hF, 0, 0, 1'b0);
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 1'b0);
    check_blink(32'd3, 4'hA);
    axi_write(4'h0, 32'h3, 4'hF, 0, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("static_led", led, 4'hA);
    end
    for (int k = 0; k < 4; k++) begin
      per = 32'($urandom_range(0, 6));
      pat = 4'($urandom_range(1, 15));
      axi_write(4'h0, 32'h0, 4'hF, 0, 0, 1'b0);
      axi_write(4'h8, {$urandom, pat} >> 0, 4'hF, 0, 0, 1'b0);
      axi_write(4'h4, per, 4'hF, 0, 0, 1'b0);
      axi_write(4'h0, 32'h1, 4'hF, 0, 0, 1'b0);
      check_blink(per, pat);
    end

    // Backpressure on both response channels
    axi_write(4'hC, 32'h5A5A_1234, 4'hF, 0, 10, 1'b0);
    axi_read(4'hC, mdl[3], 10, 1'b0);

    // Reset with a write in W_RESP and a read in R_DATA
    axi_write(4'h8, 32'h0000_000A, 4'hF, 0, 0, 1'b0);
    axi_write(4'h0, 32'h3, 4'hF, 0, 0, 1'b0);
    @(negedge clk);
    check_eq("pre_rst_led", led, 4'hA);
    axi_write(4'hC, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b1);
    axi_read(4'h4, mdl[1], 0, 1'b1);
    areset = 1'b1;
    @(negedge clk);
    check_eq("midrst_bvalid", bvalid, 0);
    check_eq("midrst_rvalid", rvalid, 0);
    check_eq("midrst_led", led, 0);
    check_eq("midrst_rdata", rdata, 0);
    areset = 1'b0;
    for (int r = 0; r < 4; r++) mdl[r] = '0;
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
